// File: rtl/sterownik_wyswietlacza.sv
// Multiplexed 4-digit 7-segment clock display driver (HH:MM) with
// anti-ghosting blanking, leading-zero suppression and a blinking colon.
module sterownik_wyswietlacza #(
  parameter int SCAN_DIV     = 4,
  parameter int BLINK_FRAMES = 2,
  parameter bit BLANK_LZ     = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] hr1_i,
  input  logic [3:0] hr2_i,
  input  logic [3:0] min1_i,
  input  logic [3:0] min2_i,
  output logic [3:0] an_o,
  output logic [6:0] seg_o,
  output logic       dp_o
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = SEG_DASH;
    endcase
  endfunction

  // Counters describe the position of the output cycle registered at the next edge.
  logic [SW-1:0] slot_q, slot_d;
  logic [1:0]    idx_q, idx_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          blink_q, blink_d;
  logic [1:0]    hr1_q, hr1_d;
  logic [3:0]    hr2_q, hr2_d, min1_q, min1_d, min2_q, min2_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    digit;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q  <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      blink_q <= 1'b0;
      hr1_q   <= '0;
      hr2_q   <= '0;
      min1_q  <= '0;
      min2_q  <= '0;
      an_q    <= 4'hF;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else begin
      slot_q  <= slot_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      blink_q <= blink_d;
      hr1_q   <= hr1_d;
      hr2_q   <= hr2_d;
      min1_q  <= min1_d;
      min2_q  <= min2_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  // Next-state: scan counters, frame/blink counter, frame-start snapshot.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    slot_d  = slot_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    blink_d = blink_q;
    hr1_d   = hr1_q;
    hr2_d   = hr2_q;
    min1_d  = min1_q;
    min2_d  = min2_q;

    if (slot_q == '0 && idx_q == 2'd0) begin
      hr1_d  = hr1_i;
      hr2_d  = hr2_i;
      min1_d = min1_i;
      min2_d = min2_i;
    end

    if (slot_q == SLOT_LAST) begin
      slot_d = '0;
      idx_d  = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        if (frame_q == FRAME_LAST) begin
          frame_d = '0;
          blink_d = ~blink_q;
        end else begin
          frame_d = frame_q + 1'b1;
        end
      end
    end else begin
      slot_d = slot_q + 1'b1;
    end
  end

  // Outputs use the _d snapshot so the frame-start cycle already shows the new capture.
  always_comb begin
    case (idx_q)
      2'd0:    digit = min2_d;
      2'd1:    digit = min1_d;
      2'd2:    digit = hr2_d;
      default: digit = (hr1_d == 2'd3) ? 4'hF : {2'b00, hr1_d};
    endcase

    seg_d = seg_of(digit);
    an_d  = (slot_q == '0) ? 4'hF : ~(4'b0001 << idx_q);
    dp_d  = ~(idx_q == 2'd2 && slot_q != '0 && blink_q);

    if (BLANK_LZ && idx_q == 2'd3 && hr1_d == 2'd0) begin
      an_d  = 4'hF;
      seg_d = SEG_BLANK;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;
  assign dp_o  = dp_q;

endmodule

// File: tb/tb_sterownik_wyswietlacza.sv
// Scoreboard bench for sterownik_wyswietlacza: the driver queues hand-computed
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_sterownik_wyswietlacza;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [1:0] hr1_i;
  logic [3:0] hr2_i, min1_i, min2_i;
  logic [3:0] an_o;
  logic [6:0] seg_o;
  logic       dp_o;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } out_t;

  typedef struct {
    out_t o;
    int   tag;
  } item_t;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, SD = 7'b0111111, SB = 7'b1111111;
  localparam out_t RST_OUT = '{an: 4'hF, seg: SB, dp: 1'b1};

  item_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  always #5 clk = ~clk;

  sterownik_wyswietlacza #(
    .SCAN_DIV(4),
    .BLINK_FRAMES(2),
    .BLANK_LZ(1'b1)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .hr1_i (hr1_i),
    .hr2_i (hr2_i),
    .min1_i(min1_i),
    .min2_i(min2_i),
    .an_o  (an_o),
    .seg_o (seg_o),
    .dp_o  (dp_o)
  );

  task automatic check(input int tag, input out_t act, input out_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL out_f%0d_c%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
               tag / 100, tag % 100, act.an, act.seg, act.dp, exp.an, exp.seg, exp.dp);
    end
  endtask

  // Monitor: one registered output per cycle, sampled mid-cycle.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        it = exp_q.pop_front();
        check(it.tag, '{an: an_o, seg: seg_o, dp: dp_o}, it.o);
      end
    end
  end

  // Queue the output expected after the next edge, then advance one cycle.
  task automatic step(input out_t e, input int tag);
    item_t it;
    it.o   = e;
    it.tag = tag;
    exp_q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input logic [1:0] h1, input logic [3:0] h2,
                          input logic [3:0] m1, input logic [3:0] m2);
    hr1_i  = h1;
    hr2_i  = h2;
    min1_i = m1;
    min2_i = m2;
  endtask

  // Expected cycles first..last of one 16-cycle frame; s0..s3 are slot segments.
  task automatic run_frame(input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3,
                           input bit blank3, input bit dp_on,
                           input int first, input int last, input int frame_tag);
    logic [3:0] en_tab[4];
    logic [6:0] seg_tab[4];
    out_t e;
    en_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_tab = '{s0, s1, s2, s3};
    for (int i = first; i <= last; i++) begin
      int k, c;
      k = i / 4;
      c = i % 4;
      e.an  = (c == 0) ? 4'hF : en_tab[k];
      e.seg = seg_tab[k];
      e.dp  = !(dp_on && k == 2 && c != 0);
      if (k == 3 && blank3) begin
        e.an  = 4'hF;
        e.seg = SB;
      end
      step(e, frame_tag * 100 + i);
    end
  endtask

  initial begin
    int budget;
    rst_i = 1'b1;
    set_time(2'd2, 4'd7, 4'd5, 4'd9);
    step(RST_OUT, 9900);
    set_time(2'd1, 4'hC, 4'hB, 4'd3);
    step(RST_OUT, 9901);
    rst_i = 1'b0;

    // Frame 0: 12:34, colon off.
    set_time(2'd1, 4'd2, 4'd3, 4'd4);
    run_frame(S4, S3, S2, S1, 1'b0, 1'b0, 0, 15, 0);
    // Frame 1: min2 changes during hr2 slot; display keeps the snapshot.
    run_frame(S4, S3, S2, S1, 1'b0, 1'b0, 0, 9, 1);
    min2_i = 4'd7;
    run_frame(S4, S3, S2, S1, 1'b0, 1'b0, 10, 15, 1);
    // Frame 2: new snapshot 12:37, colon on.
    run_frame(S7, S3, S2, S1, 1'b0, 1'b1, 0, 15, 2);
    // Frame 3: invalid min2 and hr1=3 show dashes with enables active.
    set_time(2'd3, 4'd2, 4'd3, 4'hA);
    run_frame(SD, S3, S2, SD, 1'b0, 1'b1, 0, 15, 3);
    // Frame 4: 09:58, leading hour digit blanked, colon off.
    set_time(2'd0, 4'd9, 4'd5, 4'd8);
    run_frame(S8, S5, S9, SB, 1'b1, 1'b0, 0, 15, 4);
    // Frame 5: 23:59.
    set_time(2'd2, 4'd3, 4'd5, 4'd9);
    run_frame(S9, S5, S3, S2, 1'b0, 1'b0, 0, 15, 5);
    // Frame 6: 10:06 with colon on, then reset mid-hr2-slot.
    set_time(2'd1, 4'd0, 4'd0, 4'd6);
    run_frame(S6, S0, S0, S1, 1'b0, 1'b1, 0, 9, 6);
    rst_i = 1'b1;
    set_time(2'd1, 4'd2, 4'd3, 4'd4);
    step(RST_OUT, 9902);
    rst_i = 1'b0;
    // Restart: frame 0 again with colon off, then frame 1 shows 28:88.
    run_frame(S4, S3, S2, S1, 1'b0, 1'b0, 0, 15, 7);
    set_time(2'd2, 4'd8, 4'd8, 4'd8);
    run_frame(S8, S8, S8, S2, 1'b0, 1'b0, 0, 15, 8);

    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected outputs left unchecked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sterownik_wyswietlacza.md
STEROWNIK_WYSWIETLACZA -- requirements
Module: sterownik_wyswietlacza

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4, meaning clock cycles per digit slot (legal values >= 2).
REQ-002 SHALL have parameter BLINK_FRAMES, default 2, meaning full frames per colon toggle (legal values >= 1).
REQ-003 SHALL have parameter BLANK_LZ, default 1, meaning 1 = blank the leading hour tens digit when it is 0.
REQ-004 SHALL have one clock and a synchronous active-high reset: clk_i (input, 1 bit, rising edge) and rst_i (input, 1 bit).
REQ-005 SHALL have hr1_i: input, 2 bits, hour tens BCD, from the time-keeping counter.
REQ-006 SHALL have hr2_i: input, 4 bits, hour units BCD.
REQ-007 SHALL have min1_i: input, 4 bits, minute tens BCD.
REQ-008 SHALL have min2_i: input, 4 bits, minute units BCD.
REQ-009 SHALL have an_o: output, 4 bits, active-low digit enables; bit0 = min2, bit1 = min1, bit2 = hr2, bit3 = hr1.
REQ-010 SHALL have seg_o: output, 7 bits, active-low segments {g,f,e,d,c,b,a}.
REQ-011 SHALL have dp_o: output, 1 bit, active-low colon/decimal point.

Function
REQ-012 SHALL keep a slot counter 0..SCAN_DIV-1 and a digit index 0..3 that advances by 1 when the counter wraps; index 3 wraps to 0; one frame = 4*SCAN_DIV cycles.
REQ-013 SHALL snapshot all four inputs into internal registers on the edge that starts slot 0, including the first slot 0 after reset; input changes at any other time take effect only from the next frame.
REQ-014 SHALL register all outputs; output slot k occupies SCAN_DIV consecutive cycles, in the order min2, min1, hr2, hr1.
REQ-015 SHALL drive an_o=1111 in the first cycle of every slot as anti-ghosting blanking; in the remaining SCAN_DIV-1 cycles only bit k is low.
REQ-016 SHALL drive seg_o with the digit of slot k for the whole slot; encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-017 SHALL display a dash (0111111) for any snapshot digit >9, and for hr1 = 3.
REQ-018 SHALL, when BLANK_LZ=1 and snapshot hr1=0, hold an_o=1111 and seg_o=1111111 for the whole hr1 slot; a value of 3 is never blanked.
REQ-019 SHALL keep a frame counter 0..BLINK_FRAMES-1 and a blink bit that toggles when that counter wraps at a frame boundary.
REQ-020 SHALL drive dp_o low only during the enabled cycles of the hr2 slot while the blink bit = 1; dp_o = 1 at all other times.
REQ-021 SHALL define the display as a pure function of the snapshot and counters; there are no handshake or ready signals, and the block never stalls.

Reset
REQ-022 SHALL, on any clock edge with rst_i=1, set slot counter=0, index=0, frame counter=0, blink bit=0, snapshots=0, an_o=1111, seg_o=1111111, dp_o=1.
REQ-023 SHALL let rst_i override all other activity, including assertion mid-slot or mid-frame; the first cycle after release starts a fresh frame at slot 0 with a new snapshot.

Verification (SCAN_DIV=4, BLINK_FRAMES=2, BLANK_LZ=1)
REQ-024 SHALL cover reset: hold rst_i 2 cycles with arbitrary inputs -> an_o=1111, seg_o=1111111, dp_o=1 throughout.
REQ-025 SHALL cover normal display: inputs 1,2,3,4 (12:34) -> per 16-cycle frame: min2 slot seg 0011001 with an_o 1111 then 1110 x3; min1 0110000/1101; hr2 0100100/1011; hr1 1111001/0111.
REQ-026 SHALL cover snapshot timing: change min2_i 4->7 during the hr2 slot -> the rest of the frame is unchanged, and the next min2 slot shows 1111000.
REQ-027 SHALL cover invalid digits: min2_i=4'hA and hr1_i=3 -> seg_o=0111111 in both slots, with enables active.
REQ-028 SHALL cover leading-zero blanking: hr1_i=0, hr2_i=9 -> an_o never has bit3 low, and the hr2 slot shows 0010000.
REQ-029 SHALL cover colon blink and reset recovery: dp_o is high in frames 0-1 and low in the hr2 slot cycles 2-4 of frames 2-3; asserting rst_i for 1 cycle mid-frame 2 -> outputs go to reset values, then frame 0 restarts with dp_o high.
